regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port among N_REQ writeback sources (ALU, load unit, CSR unit).
//  Round-robin arbitration over valid/ready requests; the winner is registered and driven to the register
//  file write port one cycle later. Sits between the writeback sources and the register file.
//  Drops writes to x0. Counts arbitration conflict cycles for performance debug.
// PARAMETERS
//  N_REQ     3   number of writeback requesters (2..8)
//  ADDR_W    5   register address width
//  DATA_W    32  writeback data width
//  CNT_W     16  width of conflict counter
// PORTS
//  clock          in   1             clock
//  reset          in   1             synchronous, active-high reset
//  req_valid      in   N_REQ         requester i has a write pending
//  req_addr       in   N_REQ*ADDR_W  dest register of requester i, slice [i*ADDR_W +: ADDR_W]
//  req_data       in   N_REQ*DATA_W  writeback data of requester i, slice [i*DATA_W +: DATA_W]
//  req_ready      out  N_REQ         one-hot grant; request accepted when valid&ready
//  write_register_enable out 1      to register file write enable
//  write_address  out  ADDR_W        to register file write address
//  write_back_data out DATA_W        to register file write data
//  conflict_count out  CNT_W         saturating count of cycles with >1 valid request
// BEHAVIOUR
//  - Reset (clock/reset: reset is synchronous, active-high; clock is clock): rr_ptr=0; write_register_enable=0,
//    write_address=0, write_back_data=0, conflict_count=0. req_ready=0 in every cycle where reset=1.
//  - Grant (combinational): scan i = rr_ptr, rr_ptr+1, ... mod N_REQ; first i with req_valid[i] gets
//    req_ready[i]=1. All other ready bits are 0. No valid request means req_ready = 0.
//  - Pointer: on accept by requester g, rr_ptr <= (g+1) mod N_REQ. With no accept, rr_ptr holds.
//  - Requesters hold valid, addr and data stable until accepted. The arbiter never revokes a grant within
//    a cycle. ready does not depend on the previous cycle's ready.
//  - Output stage, 1-cycle latency: on the clock edge after an accept with addr!=0,
//    write_register_enable=1 and address/data are those of the winner.
//  - If the accept has addr==0, or there is no accept, write_register_enable=0. address/data hold their
//    last value. An x0 request is still accepted (ready=1) and is counted as a normal grant.
//  - Throughput: one write per cycle. Back-to-back accepts produce consecutive write pulses.
//  - Starvation bound: a held request is granted within N_REQ cycles.
//  - conflict_count += 1 when popcount(req_valid)>1 and reset=0. It saturates at all-ones and never wraps.
//  - Reset mid-operation: an accept in the same cycle as reset is discarded. The outputs clear per the
//    reset rules and the requester must re-present the request.
//  - Same-address writes from two requesters: serialised in grant order. The later write wins in the
//    register file. Ordering between requesters is the pipeline's responsibility.
// STRUCTURE
//  - regfile_pkg: REG_ADDR_W=5, REG_DATA_W=32, typedef wb_req_t {logic [4:0] addr; logic [31:0] data;}, and
//    localparam REG_ZERO=5'd0. The register file and this block share the package.
//  - Sub-module rr_arbiter #(N): inputs req, ptr; outputs one-hot gnt and encoded gnt_idx, plus any_gnt.
//    Purely combinational, so the output register, pointer and counter remain in this block.
// TESTING
//  1 Single req: valid[1]=1, addr=5, data=0xDEADBEEF -> ready[1]=1 same cycle. Next cycle:
//    enable=1, address=5, data=0xDEADBEEF.
//  2 All three valid and held after reset -> grants in order 0,1,2,0. rr_ptr ends at 1.
//    conflict_count increments every cycle in which more than one request is valid.
//  3 x0 write: valid[0]=1, addr=0, data=0x1234 -> ready[0]=1, enable stays 0. address/data unchanged.
//  4 Reset asserted while valid[2]=1, addr=7 -> ready=0, enable=0 next cycle, counter=0.
//    After deassert, grant goes to 2 and the write to x7 occurs one cycle later.
//  5 Saturation: with CNT_W=4, 20 conflict cycles -> conflict_count=15 and holds.
//  6 Fairness: requester 0 re-asserts every cycle, requester 2 held -> requester 2 granted within 3 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its write-port arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_gnt
);

    // ptr is always below N, so one conditional subtraction gives the wrapped index.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_gnt && req[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port among writeback sources,
// with a registered write stage, x0 suppression and a saturating conflict counter.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    write_register_enable,
    output logic [ADDR_W-1:0]       write_address,
    output logic [DATA_W-1:0]       write_back_data,
    output logic [CNT_W-1:0]        conflict_count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              any_gnt;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              conflict;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // Grants are suppressed during reset so a requester never sees a discarded accept.
    assign req_ready = reset ? '0 : gnt;
    assign win_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign win_data  = req_data[gnt_idx*DATA_W +: DATA_W];
    assign conflict  = $countones(req_valid) > 1;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr                <= '0;
            write_register_enable <= 1'b0;
            write_address         <= '0;
            write_back_data       <= '0;
            conflict_count        <= '0;
        end else begin
            write_register_enable <= 1'b0;
            if (any_gnt) begin
                rr_ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                // x0 writes are accepted but never reach the register file.
                if (win_addr != ADDR_W'(REG_ZERO)) begin
                    write_register_enable <= 1'b1;
                    write_address         <= win_addr;
                    write_back_data       <= win_data;
                end
            end
            if (conflict && (conflict_count != '1)) begin
                conflict_count <= conflict_count + 1'b1;
            end
        end
    end

endmodule
